// File: rtl/filter_tdm.sv
// filter_tdm: time-multiplexed pulse-response filter.
// Keeps a time-stamped history of NUM_TAPS symbols. On eval it streams one step
// lookup per tap to an external fixed-latency LUT and accumulates
// (step_k - step_{k-1}) * value_k through a single multiplier.
// Optional feature macro: FILTER_TDM_SAT_EN (saturating output plus sticky sat_flag).
module filter_tdm #(
    parameter int NUM_TAPS    = 8,
    parameter int IN_WIDTH    = 8,
    parameter int DT_WIDTH    = 16,
    parameter int STEP_WIDTH  = 18,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_SHIFT   = 12,
    parameter int LUT_LATENCY = 2
) (
    input  logic                          clk_sys,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [IN_WIDTH-1:0]    in_value,
    input  logic [DT_WIDTH-1:0]           in_time,
    input  logic                          eval_req,
    output logic                          eval_ready,
    input  logic [DT_WIDTH-1:0]           time_next,
    output logic                          lut_req,
    output logic [$clog2(NUM_TAPS)-1:0]   lut_tap,
    output logic [DT_WIDTH-1:0]           lut_dt,
    input  logic signed [STEP_WIDTH-1:0]  lut_step,
    output logic signed [OUT_WIDTH-1:0]   out,
    output logic                          out_valid
`ifdef FILTER_TDM_SAT_EN
    ,
    output logic                          sat_flag
`endif
);

    localparam int TAP_W  = $clog2(NUM_TAPS);
    localparam int PROD_W = STEP_WIDTH + 1 + IN_WIDTH;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                       state;
    logic signed [IN_WIDTH-1:0]   val_hist  [NUM_TAPS];
    logic [DT_WIDTH-1:0]          time_hist [NUM_TAPS];
    logic [DT_WIDTH-1:0]          tnext;
    logic [TAP_W-1:0]             iss_cnt;
    logic [TAP_W-1:0]             ret_cnt;
    logic [LUT_LATENCY-1:0]       vld_pipe;
    logic signed [STEP_WIDTH-1:0] prev_step;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH-1:0]  acc_sh;
    logic [STEP_WIDTH:0]          pulse;
    logic [PROD_W-1:0]            pulse_x;
    logic [PROD_W-1:0]            val_x;
    logic [PROD_W-1:0]            prod;
    logic signed [OUT_WIDTH-1:0]  out_next;
    logic                         push;
    logic                         accept;
    logic                         ret_vld;
    logic                         ret_last;
`ifdef FILTER_TDM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    logic                         sat_hit;
`endif

    // History and evaluation share one busy window: nothing is accepted unless idle
    assign in_ready   = (state == IDLE);
    assign eval_ready = (state == IDLE);
    assign push       = in_valid & in_ready;
    assign accept     = eval_req & eval_ready;

    // Lookup strobe follows the issue counter; dt wraps modulo 2^DT_WIDTH
    assign lut_req = (state == ISSUE);
    assign lut_tap = iss_cnt;
    assign lut_dt  = lut_req ? (tnext - time_hist[iss_cnt]) : '0;

    // A return lines up with the request LUT_LATENCY cycles earlier; returns are in tap order
    assign ret_vld  = vld_pipe[LUT_LATENCY-1];
    assign ret_last = ret_vld && (ret_cnt == LAST_TAP);

    // Pulse and product are formed at full width by explicit sign extension
    always_comb begin
        pulse    = {lut_step[STEP_WIDTH-1], lut_step} - {prev_step[STEP_WIDTH-1], prev_step};
        pulse_x  = {{IN_WIDTH{pulse[STEP_WIDTH]}}, pulse};
        val_x    = {{(STEP_WIDTH+1){val_hist[ret_cnt][IN_WIDTH-1]}}, val_hist[ret_cnt]};
        prod     = pulse_x * val_x;
        acc_next = acc + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
        acc_sh   = acc_next >>> OUT_SHIFT;
`ifdef FILTER_TDM_SAT_EN
        sat_hit  = 1'b0;
        if (acc_sh > SAT_MAX) begin
            out_next = SAT_MAX[OUT_WIDTH-1:0];
            sat_hit  = 1'b1;
        end else if (acc_sh < SAT_MIN) begin
            out_next = SAT_MIN[OUT_WIDTH-1:0];
            sat_hit  = 1'b1;
        end else begin
            out_next = acc_sh[OUT_WIDTH-1:0];
        end
`else
        out_next = acc_sh[OUT_WIDTH-1:0];
`endif
    end

    // Symbol history shift register; frozen while an evaluation is in flight
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                val_hist[k]  <= '0;
                time_hist[k] <= '0;
            end
        end else if (push) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) begin
                val_hist[k]  <= val_hist[k-1];
                time_hist[k] <= time_hist[k-1];
            end
            val_hist[0]  <= in_value;
            time_hist[0] <= in_time;
        end
    end

    // Control FSM plus the return/accumulate datapath; reset drops any in-flight returns
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tnext     <= '0;
            iss_cnt   <= '0;
            ret_cnt   <= '0;
            vld_pipe  <= '0;
            prev_step <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
`ifdef FILTER_TDM_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            vld_pipe  <= (vld_pipe << 1) | LUT_LATENCY'(lut_req);
            out_valid <= 1'b0;
            if (ret_vld) begin
                acc       <= acc_next;
                prev_step <= lut_step;
                ret_cnt   <= ret_cnt + 1'b1;
                if (ret_last) begin
                    ret_cnt   <= '0;
                    out       <= out_next;
                    out_valid <= 1'b1;
`ifdef FILTER_TDM_SAT_EN
                    if (sat_hit) sat_flag <= 1'b1;
`endif
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        tnext     <= time_next;
                        acc       <= '0;
                        prev_step <= '0;
                        iss_cnt   <= '0;
                        ret_cnt   <= '0;
`ifdef FILTER_TDM_SAT_EN
                        sat_flag  <= 1'b0;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    iss_cnt <= iss_cnt + 1'b1;
                    if (iss_cnt == LAST_TAP) begin
                        iss_cnt <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ret_last) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_tdm.sv
// tb_filter_tdm: directed plus randomized checks of filter_tdm against a
// sum-of-pulses reference model. The bench LUT returns step = dt after 2 cycles.
module tb_filter_tdm;

    localparam int NT = 4;
    localparam int LL = 2;
    localparam int IW = 8;
    localparam int DW = 16;
    localparam int SW = 18;
    localparam int AW = 40;
`ifdef FILTER_TDM_SAT_EN
    localparam int OW = 4;
`else
    localparam int OW = 16;
`endif
    localparam int OS = 0;

    logic                  clk_sys = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [IW-1:0]  in_value = '0;
    logic [DW-1:0]         in_time = '0;
    logic                  eval_req = 1'b0;
    logic                  eval_ready;
    logic [DW-1:0]         time_next = '0;
    logic                  lut_req;
    logic [1:0]            lut_tap;
    logic [DW-1:0]         lut_dt;
    logic signed [SW-1:0]  lut_step;
    logic signed [OW-1:0]  dout;
    logic                  out_valid;
`ifdef FILTER_TDM_SAT_EN
    logic                  sat_flag;
    bit                    sat_exp;
`endif

    int total = 0;
    int bad = 0;

    filter_tdm #(
        .NUM_TAPS(NT), .IN_WIDTH(IW), .DT_WIDTH(DW), .STEP_WIDTH(SW),
        .ACC_WIDTH(AW), .OUT_WIDTH(OW), .OUT_SHIFT(OS), .LUT_LATENCY(LL)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_time(in_time),
        .eval_req(eval_req), .eval_ready(eval_ready), .time_next(time_next),
        .lut_req(lut_req), .lut_tap(lut_tap), .lut_dt(lut_dt), .lut_step(lut_step),
        .out(dout), .out_valid(out_valid)
`ifdef FILTER_TDM_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // External LUT: step = dt, valid two cycles after the request; not reset on purpose
    logic signed [SW-1:0] l1 = '0;
    logic signed [SW-1:0] l2 = '0;
    always @(posedge clk_sys) begin
        l1 <= lut_req ? SW'(lut_dt) : '0;
        l2 <= l1;
    end
    assign lut_step = l2;

    // Lookup stream and strobe monitor
    int dt_q[$];
    int tap_q[$];
    int ov_cnt = 0;
    always @(negedge clk_sys) begin
        if (lut_req === 1'b1) begin
            dt_q.push_back(int'(lut_dt));
            tap_q.push_back(int'(lut_tap));
        end
        if (out_valid === 1'b1) ov_cnt++;
    end

    // Reference model: history as plain arrays, output as a sum of pulses
    int mv[NT];
    int mt[NT];

    function automatic void m_clear();
        for (int k = 0; k < NT; k++) begin
            mv[k] = 0;
            mt[k] = 0;
        end
    endfunction

    function automatic void m_push(int v, int t);
        for (int k = NT - 1; k > 0; k--) begin
            mv[k] = mv[k-1];
            mt[k] = mt[k-1];
        end
        mv[0] = v;
        mt[0] = t & 'hFFFF;
    endfunction

    function automatic int m_dt(int tn, int k);
        return (tn - mt[k]) & 'hFFFF;
    endfunction

    function automatic longint m_eval(int tn);
        longint acc;
        longint prev;
        longint st;
        logic signed [OW-1:0] tr;
        longint hi;
        acc  = 0;
        prev = 0;
        for (int k = 0; k < NT; k++) begin
            st   = longint'(m_dt(tn, k));
            acc  = acc + (st - prev) * longint'(mv[k]);
            prev = st;
        end
        acc = acc >>> OS;
        hi  = (longint'(1) <<< (OW - 1)) - 1;
`ifdef FILTER_TDM_SAT_EN
        sat_exp = 1'b0;
        if (acc > hi) begin
            sat_exp = 1'b1;
            return hi;
        end
        if (acc < -hi - 1) begin
            sat_exp = 1'b1;
            return -hi - 1;
        end
`endif
        tr = acc[OW-1:0];
        return longint'(tr);
    endfunction

    task automatic chk(string tag, longint obs, longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        eval_req = 1'b0;
        m_clear();
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_push(int v, int t);
        in_valid = 1'b1;
        in_value = IW'(v);
        in_time  = DW'(t);
        @(posedge clk_sys);
        #1;
        in_valid = 1'b0;
        m_push(v, t);
    endtask

    // One evaluation, optionally with a push in the accept cycle; leaves the DUT idle
    task automatic run_eval(string tag, int tn, bit with_push, int pv, int pt);
        int n;
        longint exp;
        dt_q.delete();
        tap_q.delete();
        ov_cnt = 0;
        if (with_push) begin
            in_valid = 1'b1;
            in_value = IW'(pv);
            in_time  = DW'(pt);
        end
        eval_req  = 1'b1;
        time_next = DW'(tn);
        @(posedge clk_sys);
        #1;
        in_valid = 1'b0;
        eval_req = 1'b0;
        if (with_push) m_push(pv, pt);
        exp = m_eval(tn);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        chk({tag, ".latency"}, n, NT + LL + 1);
        chk({tag, ".out"}, longint'(dout), exp);
`ifdef FILTER_TDM_SAT_EN
        chk({tag, ".sat_flag"}, longint'(sat_flag), longint'(sat_exp));
`endif
        chk({tag, ".ndt"}, dt_q.size(), NT);
        for (int k = 0; k < NT && k < dt_q.size(); k++) begin
            chk({tag, ".dt"}, dt_q[k], m_dt(tn, k));
            chk({tag, ".tap"}, tap_q[k], k);
        end
        @(posedge clk_sys);
        #1;
        chk({tag, ".strobe_once"}, ov_cnt, 1);
        chk({tag, ".strobe_low"}, longint'(out_valid), 0);
        chk({tag, ".out_hold"}, longint'(dout), exp);
        chk({tag, ".idle"}, longint'(eval_ready), 1);
    endtask

    initial begin
        int n;
        int v;
        int t;
        int np;
        longint exp;
        bit busy_ok;

        // 1. reset values and empty-history evaluation
        m_clear();
        #2;
        chk("rst.in_ready", longint'(in_ready), 1);
        chk("rst.eval_ready", longint'(eval_ready), 1);
        chk("rst.out", longint'(dout), 0);
        chk("rst.out_valid", longint'(out_valid), 0);
        chk("rst.lut_req", longint'(lut_req), 0);
        do_reset();
        run_eval("t1", 100, 1'b0, 0, 0);
        chk("t1.out_const", longint'(dout), 0);
        chk("t1.dt3_const", dt_q.size() == NT ? dt_q[3] : -1, 100);

        // 2. single tap
        do_reset();
        do_push(1, 10);
        run_eval("t2", 15, 1'b0, 0, 0);
        chk("t2.dt0_const", dt_q.size() == NT ? dt_q[0] : -1, 5);
`ifndef FILTER_TDM_SAT_EN
        chk("t2.out_const", longint'(dout), 5);
`endif

        // 3. full history
        do_reset();
        do_push(1, 0);
        do_push(-1, 4);
        do_push(2, 8);
        do_push(3, 12);
        run_eval("t3", 14, 1'b0, 0, 0);
`ifndef FILTER_TDM_SAT_EN
        chk("t3.out_const", longint'(dout), 14);
`endif

        // 4a. push and eval in the same cycle: new value is used
        run_eval("t4a", 40, 1'b1, -5, 30);

        // 4b. push held while busy, accepted the cycle after out_valid
        eval_req  = 1'b1;
        time_next = DW'(60);
        @(posedge clk_sys);
        #1;
        eval_req = 1'b0;
        exp      = m_eval(60);
        in_valid = 1'b1;
        in_value = IW'(7);
        in_time  = DW'(55);
        busy_ok  = 1'b1;
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk_sys);
            #1;
            n++;
        end
        chk("t4b.latency", n, NT + LL + 1);
        chk("t4b.out", longint'(dout), exp);
        chk("t4b.busy_blocked", longint'(busy_ok), 1);
        chk("t4b.ready_at_strobe", longint'(in_ready), 0);
        @(posedge clk_sys);
        #1;
        chk("t4b.ready_after", longint'(in_ready), 1);
        @(posedge clk_sys);
        #1;
        in_valid = 1'b0;
        m_push(7, 55);
        run_eval("t4c", 70, 1'b0, 0, 0);

        // 5. timestamp wrap
        do_reset();
        do_push(3, 'hFFFE);
        run_eval("t5", 3, 1'b0, 0, 0);
        chk("t5.dt0_const", dt_q.size() == NT ? dt_q[0] : -1, 5);

        // 6. reset mid-evaluation: aborted, no strobe, history and out cleared
        do_push(9, 100);
        do_push(-4, 120);
        run_eval("t6pre", 200, 1'b0, 0, 0);
        eval_req  = 1'b1;
        time_next = DW'(300);
        @(posedge clk_sys);
        #1;
        eval_req = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        ov_cnt = 0;
        rst_n  = 1'b0;
        #1;
        chk("t6.lut_req_rst", longint'(lut_req), 0);
        chk("t6.out_rst", longint'(dout), 0);
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        m_clear();
        repeat (10) @(posedge clk_sys);
        #1;
        chk("t6.no_strobe", ov_cnt, 0);
        chk("t6.out_zero", longint'(dout), 0);
        chk("t6.ready", longint'(in_ready), 1);
        run_eval("t6post", 100, 1'b0, 0, 0);

        // saturation boundary (wraps in the default build, clamps when enabled)
        do_reset();
        do_push(1, 0);
        run_eval("tsat", 20, 1'b0, 0, 0);

        // randomized history and evaluation times
        for (int it = 0; it < 16; it++) begin
            np = int'($urandom_range(0, 3));
            for (int p = 0; p < np; p++) begin
                v = int'($urandom_range(0, 255)) - 128;
                t = int'($urandom_range(0, 65535));
                do_push(v, t);
            end
            v = int'($urandom_range(0, 255)) - 128;
            t = int'($urandom_range(0, 65535));
            run_eval("rnd", int'($urandom_range(0, 65535)), bit'($urandom_range(0, 1)), v, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
